// File: rtl/deser_8x1b.sv
// ============================================================================
// Module      : deser_8x1b
// Description : Serial-to-parallel collector; gathers eight 1-bit transfers
//               into a byte and presents it on a val/rdy output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser_8x1b #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic       in_bit,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out_data,
    output logic [2:0] count
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  data_q,  data_d;

    logic        w_in_xfer;
    logic [2:0]  w_slot;

    // In FULL the input side only opens when the consumer drains the byte on
    // the same edge, giving back-to-back words without a bubble.
    assign in_rdy    = reset & ((state_q == ST_FILL) | out_rdy);
    assign w_in_xfer = in_val & in_rdy;
    assign w_slot    = MSB_FIRST ? (3'd7 - count_q) : count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        if (clear) begin
            state_d = ST_FILL;
            count_d = 3'd0;
        end else if (w_in_xfer) begin
            data_d[w_slot] = in_bit;
            count_d        = count_q + 3'd1;
            // count is 0 in FULL, so an overlapping write restarts the word.
            if ((state_q == ST_FILL) && (count_q == 3'd7)) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_FILL;
            end
        end else if ((state_q == ST_FULL) && out_rdy) begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FILL;
            count_q <= 3'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign out_val  = (state_q == ST_FULL);
    assign out_data = data_q;
    assign count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_deser_8x1b.sv
// ============================================================================
// Module      : tb_deser_8x1b
// Description : Directed self-checking bench for deser_8x1b, both bit orders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deser_8x1b;

    logic       clk = 1'b0;
    logic       reset, clear, in_val, in_bit, out_rdy;
    logic       in_rdy0, out_val0, in_rdy1, out_val1;
    logic [7:0] out_data0, out_data1;
    logic [2:0] count0, count1;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    deser_8x1b #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_val(in_val), .in_rdy(in_rdy0), .in_bit(in_bit),
        .out_val(out_val0), .out_rdy(out_rdy), .out_data(out_data0), .count(count0)
    );

    deser_8x1b #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_val(in_val), .in_rdy(in_rdy1), .in_bit(in_bit),
        .out_val(out_val1), .out_rdy(out_rdy), .out_data(out_data1), .count(count1)
    );

    // Model: a byte being built, how many bits are in it, and whether a
    // completed byte is waiting for the consumer.
    logic [7:0] m_data [2];
    int         m_n    [2];
    bit         m_full [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_data[d] = 8'h00;
            m_n[d]    = 0;
            m_full[d] = 1'b0;
        end
    end

    function automatic bit model_rdy(int d);
        return reset && (!m_full[d] || out_rdy);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic logic [7:0] nd = m_data[d];
            automatic int         nn = m_n[d];
            automatic bit         nf = m_full[d];
            automatic int         pos;
            if (!reset) begin
                nd = 8'h00; nn = 0; nf = 1'b0;
            end else if (clear) begin
                nn = 0; nf = 1'b0;
            end else if (in_val && model_rdy(d)) begin
                pos = (d == 1) ? 7 - nn : nn;
                nd[pos] = in_bit;
                if (nf) begin
                    nf = 1'b0; nn = 1;
                end else begin
                    nn = nn + 1;
                    if (nn == 8) begin
                        nf = 1'b1; nn = 0;
                    end
                end
            end else if (nf && out_rdy) begin
                nf = 1'b0;
            end
            m_data[d] <= nd;
            m_n[d]    <= nn;
            m_full[d] <= nf;
        end
        started <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m0.out_val",  int'(out_val0),  int'(m_full[0]));
            chk("m0.out_data", int'(out_data0), int'(m_data[0]));
            chk("m0.count",    int'(count0),    m_n[0]);
            chk("m0.in_rdy",   int'(in_rdy0),   int'(model_rdy(0)));
            chk("m1.out_val",  int'(out_val1),  int'(m_full[1]));
            chk("m1.out_data", int'(out_data1), int'(m_data[1]));
            chk("m1.count",    int'(count1),    m_n[1]);
            chk("m1.in_rdy",   int'(in_rdy1),   int'(model_rdy(1)));
        end
    end

    task automatic cyc(input logic v, input logic b, input logic ordy, input logic clr);
        in_val  = v;
        in_bit  = b;
        out_rdy = ordy;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] lsb_first, input logic ordy);
        for (int i = 0; i < 8; i++) cyc(1'b1, lsb_first[i], ordy, 1'b0);
    endtask

    task automatic lit(input string name, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
        @(negedge clk);
        chk({name, ".val0"},  int'(out_val0),  int'(v0));
        chk({name, ".data0"}, int'(out_data0), int'(d0));
        chk({name, ".val1"},  int'(out_val1),  int'(v1));
        chk({name, ".data1"}, int'(out_data1), int'(d1));
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_val = 1'b1; in_bit = 1'b1; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.in_rdy0", int'(in_rdy0), 0);
        chk("rst.in_rdy1", int'(in_rdy1), 0);
        chk("rst.count0",  int'(count0),  0);
        lit("rst", 1'b0, 8'h00, 1'b0, 8'h00);
        reset = 1'b1; in_val = 1'b0;
        @(negedge clk);
        chk("rel.in_rdy0", int'(in_rdy0), 1);

        // A5 is its own bit reverse, so both orders give A5.
        send_byte(8'hA5, 1'b0);
        in_val = 1'b0;
        lit("a5", 1'b1, 8'hA5, 1'b1, 8'hA5);
        chk("a5.in_rdy0", int'(in_rdy0), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        lit("a5hold", 1'b1, 8'hA5, 1'b1, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        lit("a5drain", 1'b0, 8'hA5, 1'b0, 8'hA5);

        // Bits 1,1,0,0,0,0,0,0: LSB-first 03, MSB-first C0.
        send_byte(8'h03, 1'b0);
        lit("c0", 1'b1, 8'h03, 1'b1, 8'hC0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back 3C then FF with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            automatic logic [15:0] s = 16'hFF3C;
            cyc(1'b1, s[i], 1'b1, 1'b0);
            if (i == 7)  lit("b2b.3c", 1'b1, 8'h3C, 1'b1, 8'h3C);
            if (i == 8) begin
                @(negedge clk);
                chk("b2b.count0", int'(count0), 1);
                chk("b2b.count1", int'(count1), 1);
                chk("b2b.gap0",   int'(out_val0), 0);
            end
        end
        lit("b2b.ff", 1'b1, 8'hFF, 1'b1, 8'hFF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped bits then clear carrying a 0 that must not be written.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("gap.count0", int'(count0), 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("clr.count0", int'(count0), 0);
        lit("clr", 1'b0, 8'hFF, 1'b0, 8'hFF);
        send_byte(8'h00, 1'b0);
        in_val = 1'b0;
        lit("zeros", 1'b1, 8'h00, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset while a byte is held.
        send_byte(8'hA5, 1'b0);
        in_val = 1'b0;
        lit("pre_rst", 1'b1, 8'hA5, 1'b1, 8'hA5);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst.in_rdy0", int'(in_rdy0), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        lit("mid_rst", 1'b0, 8'h00, 1'b0, 8'h00);
        chk("mid_rst.count1", int'(count1), 0);
        send_byte(8'h03, 1'b0);
        in_val = 1'b0;
        lit("fresh", 1'b1, 8'h03, 1'b1, 8'hC0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
